// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared constants for the CR16-style control unit: ALU op codes, opcode/ext fields,
// branch condition codes, FSM state encoding, PSR bit positions and condition evaluation.
`ifndef CPU_CTRL_ALUOPS
`define CPU_CTRL_ALUOPS
`define ALUOp_NOP  5'h00
`define ALUOp_ADD  5'h01
`define ALUOp_ADDU 5'h02
`define ALUOp_ADDC 5'h03
`define ALUOp_SUB  5'h04
`define ALUOp_SUBC 5'h05
`define ALUOp_CMP  5'h06
`define ALUOp_AND  5'h07
`define ALUOp_OR   5'h08
`define ALUOp_XOR  5'h09
`define ALUOp_MOV  5'h0A
`define ALUOp_LSH  5'h0B
`define ALUOp_ASHU 5'h0C
`define ALUOp_LUI  5'h0D
`endif

package cpu_ctrl_fsm_pkg;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_MEM    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP, CL_ALU, CL_CMP, CL_LOAD, CL_STOR, CL_BCOND, CL_JCOND, CL_JAL
  } iclass_t;

  localparam logic [3:0] OP_RR    = 4'b0000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_LUI   = 4'b1111;
  localparam logic [3:0] OP_CMP   = 4'b1011;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_LSH   = 4'b0100;
  localparam logic [3:0] EXT_ASHU  = 4'b0110;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_HS = 4'b1011;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;

  localparam int PSR_N = 4;
  localparam int PSR_Z = 3;
  localparam int PSR_F = 2;
  localparam int PSR_L = 1;
  localparam int PSR_C = 0;

  // Same code space for RR ext field and immediate opcode; NOP means "not an ALU op".
  function automatic logic [4:0] arith_op(input logic [3:0] code);
    case (code)
      4'b0101: arith_op = `ALUOp_ADD;
      4'b0110: arith_op = `ALUOp_ADDU;
      4'b0111: arith_op = `ALUOp_ADDC;
      4'b1001: arith_op = `ALUOp_SUB;
      4'b1010: arith_op = `ALUOp_SUBC;
      4'b1011: arith_op = `ALUOp_CMP;
      4'b0001: arith_op = `ALUOp_AND;
      4'b0010: arith_op = `ALUOp_OR;
      4'b0011: arith_op = `ALUOp_XOR;
      4'b1101: arith_op = `ALUOp_MOV;
      default: arith_op = `ALUOp_NOP;
    endcase
  endfunction

  function automatic logic cond_eval(input logic [3:0] cond, input logic [4:0] psr);
    case (cond)
      COND_EQ: cond_eval = psr[PSR_Z];
      COND_NE: cond_eval = !psr[PSR_Z];
      COND_CS: cond_eval = psr[PSR_C];
      COND_CC: cond_eval = !psr[PSR_C];
      COND_HI: cond_eval = psr[PSR_L];
      COND_LS: cond_eval = !psr[PSR_L];
      COND_GT: cond_eval = psr[PSR_N];
      COND_LE: cond_eval = !psr[PSR_N];
      COND_FS: cond_eval = psr[PSR_F];
      COND_FC: cond_eval = !psr[PSR_F];
      COND_LO: cond_eval = !psr[PSR_L] && !psr[PSR_Z];
      COND_HS: cond_eval = psr[PSR_L] || psr[PSR_Z];
      COND_LT: cond_eval = !psr[PSR_N] && !psr[PSR_Z];
      COND_GE: cond_eval = psr[PSR_N] || psr[PSR_Z];
      COND_UC: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational instruction decode: IR -> ALU op, immediate select, instruction class
// and an illegal flag for encodings outside the supported set.
module cpu_ctrl_decode
  import cpu_ctrl_fsm_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [4:0]  o_alu_op,
  output logic        o_imm_mux,
  output iclass_t     o_iclass,
  output logic        o_illegal
);

  logic [3:0] w_op;
  logic [3:0] w_ext;

  assign w_op  = i_ir[15:12];
  assign w_ext = i_ir[7:4];

  always_comb begin
    o_alu_op  = `ALUOp_NOP;
    o_imm_mux = 1'b0;
    o_iclass  = CL_NOP;
    o_illegal = 1'b0;
    case (w_op)
      OP_RR: begin
        o_alu_op = arith_op(w_ext);
        o_iclass = (w_ext == OP_CMP) ? CL_CMP : CL_ALU;
      end
      OP_SHIFT: begin
        o_iclass = CL_ALU;
        // Immediate shifts carry the amount sign bit in ext[0]
        if (w_ext[3:1] == 3'b000) begin
          o_alu_op  = `ALUOp_LSH;
          o_imm_mux = 1'b1;
        end else if (w_ext[3:1] == 3'b001) begin
          o_alu_op  = `ALUOp_ASHU;
          o_imm_mux = 1'b1;
        end else if (w_ext == EXT_LSH) begin
          o_alu_op = `ALUOp_LSH;
        end else if (w_ext == EXT_ASHU) begin
          o_alu_op = `ALUOp_ASHU;
        end
      end
      OP_LUI: begin
        o_alu_op  = `ALUOp_LUI;
        o_imm_mux = 1'b1;
        o_iclass  = CL_ALU;
      end
      OP_MEM: begin
        case (w_ext)
          EXT_LOAD:  o_iclass = CL_LOAD;
          EXT_STOR:  o_iclass = CL_STOR;
          EXT_JCOND: o_iclass = CL_JCOND;
          EXT_JAL:   o_iclass = CL_JAL;
          default:   o_iclass = CL_NOP;
        endcase
      end
      OP_BCOND: o_iclass = CL_BCOND;
      default: begin
        o_alu_op  = arith_op(w_op);
        o_imm_mux = 1'b1;
        o_iclass  = (w_op == OP_CMP) ? CL_CMP : CL_ALU;
      end
    endcase

    if ((o_iclass == CL_ALU || o_iclass == CL_CMP) && o_alu_op == `ALUOp_NOP) begin
      o_iclass = CL_NOP;
    end
    if (o_iclass == CL_NOP) begin
      o_illegal = 1'b1;
      o_imm_mux = 1'b0;
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM for the 16-bit CR16-style CPU: fetch, decode, execute and
// memory phases driving the reg_alu controls, PC update and memory strobes.
module cpu_ctrl_fsm
  import cpu_ctrl_fsm_pkg::*;
#(
  parameter int unsigned PC_W      = 16,
  parameter state_t      RST_STATE = S_FETCH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  input  logic [4:0]  psr_in,
  output logic        write,
  output logic        IMM_MUX,
  output logic        COND_RSLT,
  output logic        WB_MUX0,
  output logic [1:0]  WB_MUX,
  output logic [3:0]  rSrc,
  output logic [3:0]  rDst,
  output logic [4:0]  aluOp,
  output logic [7:0]  imm_in,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic [7:0]  br_disp,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        illegal
);

  // Displacement field is sign-extended to PC_W by the PC adder; never wider than the PC.
  localparam int unsigned DISP_W = (PC_W < 8) ? PC_W : 8;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_ir;
  logic        w_ir_load;
  logic [4:0]  w_alu_op;
  logic        w_imm_mux;
  iclass_t     w_iclass;
  logic        w_illegal;
  logic        w_cond_true;

  cpu_ctrl_decode u_decode (
    .i_ir      (r_ir),
    .o_alu_op  (w_alu_op),
    .o_imm_mux (w_imm_mux),
    .o_iclass  (w_iclass),
    .o_illegal (w_illegal)
  );

  assign w_cond_true = cond_eval(r_ir[11:8], psr_in);

  assign rSrc    = r_ir[3:0];
  assign rDst    = r_ir[11:8];
  assign imm_in  = r_ir[7:0];
  assign br_disp = r_ir[DISP_W-1:0];
  assign aluOp   = w_alu_op;
  assign IMM_MUX = w_imm_mux;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST_STATE;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_ir_load) begin
        r_ir <= instr;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ir_load    = 1'b0;
    write        = 1'b0;
    COND_RSLT    = 1'b0;
    WB_MUX0      = 1'b0;
    WB_MUX       = 2'b10;
    pc_en        = 1'b0;
    pc_sel       = 2'b00;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    illegal      = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_load    = 1'b1;
          pc_en        = 1'b1;
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_illegal) begin
          illegal      = 1'b1;
          w_state_next = S_FETCH;
        end else if (w_iclass == CL_LOAD || w_iclass == CL_STOR) begin
          w_state_next = S_MEM;
        end else begin
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_next = S_FETCH;
        case (w_iclass)
          CL_ALU: write = 1'b1;
          CL_BCOND: begin
            COND_RSLT = w_cond_true;
            pc_en     = w_cond_true;
            pc_sel    = 2'b01;
          end
          CL_JCOND: begin
            COND_RSLT = w_cond_true;
            pc_en     = w_cond_true;
            pc_sel    = 2'b10;
          end
          CL_JAL: begin
            write   = 1'b1;
            WB_MUX0 = 1'b1;
            WB_MUX  = 2'b00;
            pc_en   = 1'b1;
            pc_sel  = 2'b10;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (w_iclass == CL_STOR);
        if (mem_ready) begin
          if (w_iclass == CL_LOAD) begin
            write  = 1'b1;
            WB_MUX = 2'b11;
          end
          w_state_next = S_FETCH;
        end
      end
      default: w_state_next = S_FETCH;
    endcase
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control unit that sequences the reg_alu datapath (register file + ALU + writeback mux) for the 16-bit CR16-style CPU.
- Fetches each instruction through a memory handshake, latches it in an internal IR and decodes it.
- Drives every reg_alu control input, plus PC update and data-memory strobes.
- Evaluates branch conditions from reg_alu's psrOut.

Parameters:
- PC_W, 16, width of pc_ra passthrough and the branch-displacement sign extension.
- RST_STATE, S_FETCH, state entered on reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- instr  in  16  memory read data; captured into IR in S_FETCH
- mem_ready  in  1  memory handshake completion
- psr_in  in  5  reg_alu psrOut, {N,Z,F,L,C}, Z=bit3
- write  out  1  register-file write enable
- IMM_MUX  out  1  1 = ALU B operand from imm_in
- COND_RSLT  out  1  condition-evaluation result for the current instruction
- WB_MUX0  out  1  1 = link writeback (JAL)
- WB_MUX  out  2  00 pc_ra, 01 drom, 10 ALU, 11 mem_data
- rSrc  out  4  source register
- rDst  out  4  destination register
- aluOp  out  5  ALU operation, using `ALUOp_* codes
- imm_in  out  8  immediate / shift amount
- pc_en  out  1  PC update strobe
- pc_sel  out  2  00 PC+1, 01 PC+sext(disp), 10 PC<=dSrc
- br_disp  out  8  branch displacement (IR[7:0])
- mem_req  out  1  memory access request
- mem_we  out  1  1 = store
- addr_sel  out  1  0 = address from PC, 1 = address from dSrc
- illegal  out  1  one-cycle pulse on an undecodable instruction

Behaviour:
- Reset values:
  - FSM enters S_FETCH; IR cleared.
  - mem_req=1, addr_sel=0 (fetch begins immediately after reset).
  - All other outputs 0, except WB_MUX=2'b10.
  - rst is sampled every clk and overrides any state, including a pending memory handshake.
- Instruction formats:
  - RR: [15:12] op=0000, [11:8] Rdst, [7:4] ext, [3:0] Rsrc.
  - Immediate: [15:12] op, [11:8] Rdst, [7:0] imm.
  - 0100: LOAD ext=0000, STOR ext=0100, Jcond ext=1100, JAL ext=1000.
  - 1100: Bcond; cond in [11:8], disp in [7:0].
  - 1000: shifts.
  - 1111: LUI.
- S_FETCH:
  - Drives mem_req=1, addr_sel=0.
  - Holds until mem_ready=1, then loads IR<=instr, pulses pc_en with pc_sel=00 and goes to S_DECODE.
- S_DECODE:
  - Presents rSrc/rDst/aluOp/IMM_MUX/imm_in from IR, one cycle for operand read.
  - Next state: LOAD/STOR -> S_MEM; all others -> S_EXEC.
  - Undecodable: illegal=1, treated as NOP, back to S_FETCH.
- S_EXEC:
  - ALU/imm/shift/LUI: write=1, WB_MUX=10.
  - CMP/CMPI: write=0; PSR updates only.
  - Bcond/Jcond: COND_RSLT=cond(psr_in). If 1: pc_en=1, pc_sel=01 (B) or 10 (J).
  - JAL: write=1, WB_MUX0=1, WB_MUX=00, pc_en=1, pc_sel=10.
  - Always returns to S_FETCH.
- S_MEM:
  - mem_req=1, addr_sel=1; mem_we=1 for STOR.
  - Waits for mem_ready. On mem_ready, LOAD asserts write=1, WB_MUX=11 in that same cycle.
  - Then -> S_FETCH.
- Conditions:
  - EQ Z; NE !Z; CS C; CC !C; HI L; LS !L; GT N; LE !N; FS F; FC !F.
  - LO !L&!Z; HS L|Z; LT !N&!Z; GE N|Z.
  - UC (1110) = 1; 1111 = 0.
- Latency:
  - ALU/branch: 3 cycles with zero-wait memory.
  - LOAD/STOR: 3 cycles plus memory wait states.
- Strobe rules:
  - write is never asserted outside S_EXEC and S_MEM.
  - pc_en fires at most once per instruction in S_FETCH, plus at most once in S_EXEC.
- mem_ready outside S_FETCH/S_MEM is ignored.

Decomposition:
- Shared defines: `ALUOp_* codes, opcode/ext constants, condition codes, state encodings, PSR bit indices.
- One sub-module, cpu_ctrl_decode: combinational IR -> {aluOp, IMM_MUX, instruction class, illegal}.
- cpu_ctrl_fsm holds the state register, IR and condition evaluation.

Test Plan:
- Reset mid-S_MEM (STOR pending, mem_ready=0), assert rst one cycle -> next cycle S_FETCH, mem_req=1, addr_sel=0, mem_we=0, write=0.
- ADDI r1,10 (instr 16'h510A), mem_ready=1 -> S_EXEC has write=1, IMM_MUX=1, rDst=1, imm_in=10, aluOp=`ALUOp_ADD, WB_MUX=10; back in S_FETCH 3 cycles after fetch.
- LOAD r3,r2 with mem_ready delayed 3 cycles -> mem_req/addr_sel held high; write=1, WB_MUX=11, rDst=3, rSrc=2 exactly on the mem_ready cycle.
- CMP then BEQ disp=-4 with psr_in=5'b01000 -> COND_RSLT=1, pc_en=1, pc_sel=01, br_disp=8'hFC.
- Same branch with psr_in=0 -> COND_RSLT=0, pc_en=0.
- Opcode 16'h4F30 (undefined ext) -> illegal pulses one cycle, no write/mem_req; next instruction fetched normally.
